// File: rtl/galaxian_pkg.sv
// Shared galaxian types, playfield geometry and the small arithmetic helpers
// used by the alien motion logic.
package galaxian_pkg;

  typedef enum logic [2:0] {
    FORM    = 3'd0,
    DIVE    = 3'd1,
    RETURN  = 3'd2,
    EXPLODE = 3'd3,
    DEAD    = 3'd4
  } alien_state_t;

  localparam int X_MIN     = 0;
  localparam int X_MAX     = 639;
  localparam int Y_MAX     = 479;
  localparam int MISSILE_W = 3;
  localparam int MISSILE_H = 6;

  // Move cur toward tgt by at most step, never overshooting.
  function automatic logic [10:0] step_toward(input logic [10:0] cur,
                                              input logic [10:0] tgt,
                                              input logic [10:0] step);
    logic [10:0] d;
    if (tgt > cur) begin
      d = tgt - cur;
      return cur + ((d < step) ? d : step);
    end else begin
      d = cur - tgt;
      return cur - ((d < step) ? d : step);
    end
  endfunction

  function automatic logic [10:0] clamp(input logic [10:0] v,
                                        input logic [10:0] lo,
                                        input logic [10:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/diving_alien_rect_overlap.sv
// Combinational strict axis-aligned rectangle overlap test; edges that only
// touch do not count. Sums are one bit wider so nothing wraps.
module rect_overlap #(
  parameter int W = 10
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] aw,
  input  logic [W-1:0] ah,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] bw,
  input  logic [W-1:0] bh,
  output logic         hit
);

  logic x_ok, y_ok;

  assign x_ok = ({1'b0, bx} + {1'b0, bw} > {1'b0, ax}) &&
                ({1'b0, bx} < {1'b0, ax} + {1'b0, aw});
  assign y_ok = ({1'b0, by} + {1'b0, bh} > {1'b0, ay}) &&
                ({1'b0, by} < {1'b0, ay} + {1'b0, ah});
  assign hit  = x_ok && y_ok;

endmodule

// File: rtl/diving_alien.sv
// One formation alien: sweeping home slot, dive/return flight, missile hit,
// timed explosion and death.
//
// state   | meaning
// FORM    | parked in the sweeping formation slot
// DIVE    | descending toward PlayerX
// RETURN  | wrapped to top, flying back to the home slot
// EXPLODE | hit; position frozen while the explosion timer runs down
// DEAD    | invisible and inert until Reset
module diving_alien
  import galaxian_pkg::*;
#(
  parameter int ALIEN_SIZE     = 25,
  parameter int X_MIN          = galaxian_pkg::X_MIN,
  parameter int X_MAX          = galaxian_pkg::X_MAX,
  parameter int Y_MAX          = galaxian_pkg::Y_MAX,
  parameter int SWEEP_STEP     = 1,
  parameter int DIVE_DY        = 2,
  parameter int DIVE_DX        = 1,
  parameter int EXPLODE_FRAMES = 8,
  parameter int MISSILE_W      = galaxian_pkg::MISSILE_W,
  parameter int MISSILE_H      = galaxian_pkg::MISSILE_H
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] alienStX,
  input  logic [9:0] alienStY,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerMissileX,
  input  logic [9:0] PlayerMissileY,
  input  logic       missile_active,
  input  logic       dive_go,
  output logic [9:0] AlienX,
  output logic [9:0] AlienY,
  output logic [9:0] AlienS,
  output logic [2:0] alien_state,
  output logic       visible,
  output logic       hit_pulse
);

  localparam logic [10:0] SZ      = 11'(ALIEN_SIZE);
  localparam logic [10:0] STEP    = 11'(SWEEP_STEP);
  localparam logic [10:0] DY      = 11'(DIVE_DY);
  localparam logic [10:0] DX      = 11'(DIVE_DX);
  localparam logic [10:0] XLO     = 11'(X_MIN);
  localparam logic [10:0] XHI     = 11'(X_MAX);
  localparam logic [10:0] XHI_POS = 11'(X_MAX - ALIEN_SIZE);
  localparam logic [10:0] YHI     = 11'(Y_MAX);
  localparam logic [7:0]  EXP_LD  = 8'(EXPLODE_FRAMES - 1);

  alien_state_t state, state_nxt;
  logic [9:0]  home_x, home_y, pos_x, pos_y, disp_x, disp_y;
  logic        dir_right, dir_nxt;
  logic [10:0] home_x_nxt, y_step, dive_x, ret_x;
  logic [7:0]  explode_cnt;
  logic        overlap, hit_now, wrap, arrive;

  rect_overlap #(.W(10)) u_overlap (
    .ax (disp_x),
    .ay (disp_y),
    .aw (10'(ALIEN_SIZE)),
    .ah (10'(ALIEN_SIZE)),
    .bx (PlayerMissileX),
    .by (PlayerMissileY),
    .bw (10'(MISSILE_W)),
    .bh (10'(MISSILE_H)),
    .hit(overlap)
  );

  assign disp_x  = (state == FORM) ? home_x : pos_x;
  assign disp_y  = (state == FORM) ? home_y : pos_y;
  assign hit_now = overlap && missile_active &&
                   (state == FORM || state == DIVE || state == RETURN);

  assign y_step = {1'b0, pos_y} + DY;
  assign wrap   = (y_step + SZ) > YHI;
  assign arrive = y_step >= {1'b0, home_y};
  assign dive_x = clamp(step_toward({1'b0, pos_x}, {1'b0, PlayerX}, DX), XLO, XHI_POS);
  assign ret_x  = clamp(step_toward({1'b0, pos_x}, {1'b0, home_x}, DX), XLO, XHI_POS);

  // Formation sweep with edge bounce; reversing frames step the other way.
  always_comb begin
    dir_nxt    = dir_right;
    home_x_nxt = {1'b0, home_x} + STEP;
    if (dir_right) begin
      if ({1'b0, home_x} + SZ + STEP > XHI) begin
        dir_nxt    = 1'b0;
        home_x_nxt = {1'b0, home_x} - STEP;
      end
    end else begin
      if ({1'b0, home_x} < XLO + STEP) dir_nxt = 1'b1;
      else home_x_nxt = {1'b0, home_x} - STEP;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= FORM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (hit_now) begin
      state_nxt = EXPLODE;
    end else begin
      case (state)
        FORM:    if (dive_go) state_nxt = DIVE;
        DIVE:    if (wrap) state_nxt = RETURN;
        RETURN:  if (arrive) state_nxt = FORM;
        EXPLODE: if (explode_cnt == 8'd0) state_nxt = DEAD;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      home_x      <= alienStX;
      home_y      <= alienStY;
      pos_x       <= alienStX;
      pos_y       <= alienStY;
      dir_right   <= 1'b1;
      explode_cnt <= 8'd0;
      hit_pulse   <= 1'b0;
    end else begin
      hit_pulse <= hit_now;
      if (state != DEAD) begin
        home_x    <= home_x_nxt[9:0];
        dir_right <= dir_nxt;
      end
      if (hit_now) begin
        pos_x       <= disp_x;
        pos_y       <= disp_y;
        explode_cnt <= EXP_LD;
      end else begin
        case (state)
          FORM: begin
            if (dive_go) begin
              pos_x <= home_x;
              pos_y <= home_y;
            end
          end
          DIVE: begin
            pos_x <= dive_x[9:0];
            pos_y <= wrap ? 10'd0 : y_step[9:0];
          end
          RETURN: begin
            pos_x <= arrive ? home_x : ret_x[9:0];
            pos_y <= arrive ? home_y : y_step[9:0];
          end
          EXPLODE: if (explode_cnt != 8'd0) explode_cnt <= explode_cnt - 8'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    AlienX      = disp_x;
    AlienY      = disp_y;
    AlienS      = 10'(ALIEN_SIZE);
    alien_state = state;
    visible     = (state != DEAD);
  end

endmodule

// File: tb/tb_diving_alien.sv
// Directed bench for diving_alien: stimulus queues expected frame outputs,
// a negedge monitor pops and compares them.
module tb_diving_alien;
  import galaxian_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] alienStX = '0, alienStY = '0, PlayerX = '0;
  logic [9:0] PlayerMissileX = '0, PlayerMissileY = '0;
  logic       missile_active = 1'b0, dive_go = 1'b0;
  logic [9:0] AlienX, AlienY, AlienS;
  logic [2:0] alien_state;
  logic       visible, hit_pulse;

  typedef struct {
    int    cyc;
    string name;
    int    x, y, st, vis, hit;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  diving_alien dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .alienStX(alienStX), .alienStY(alienStY), .PlayerX(PlayerX),
    .PlayerMissileX(PlayerMissileX), .PlayerMissileY(PlayerMissileY),
    .missile_active(missile_active), .dive_go(dive_go),
    .AlienX(AlienX), .AlienY(AlienY), .AlienS(AlienS),
    .alien_state(alien_state), .visible(visible), .hit_pulse(hit_pulse)
  );

  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  // Monitor: compares every expectation due at or before the current frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge frame_clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk(e.name, "frame", cyc, e.cyc);
        chk(e.name, "x", int'(AlienX), e.x);
        chk(e.name, "y", int'(AlienY), e.y);
        chk(e.name, "state", int'(alien_state), e.st);
        chk(e.name, "visible", int'(visible), e.vis);
        chk(e.name, "hit_pulse", int'(hit_pulse), e.hit);
        chk(e.name, "size", int'(AlienS), 25);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic push_exp(input string nm, input int x, input int y,
                          input alien_state_t st, input int vis, input int hit);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.x = x; e.y = y;
    e.st = int'(st); e.vis = vis; e.hit = hit;
    sb.push_back(e);
  endtask

  task automatic reset_to(input int x, input int y, input string nm);
    Reset = 1'b1;
    alienStX = 10'(x);
    alienStY = 10'(y);
    tick();
    push_exp(nm, x, y, FORM, 1, 0);
    Reset = 1'b0;
  endtask

  initial begin
    // Reset and plain sweep
    reset_to(100, 50, "reset");
    tick(3);
    push_exp("sweep3", 103, 50, FORM, 1, 0);

    // Right edge bounce
    reset_to(613, 50, "bounce_reset");
    tick(); push_exp("bounce_614", 614, 50, FORM, 1, 0);
    tick(); push_exp("bounce_rev", 613, 50, FORM, 1, 0);
    tick(); push_exp("bounce_left", 612, 50, FORM, 1, 0);

    // Full dive, wrap and return
    reset_to(100, 50, "dive_reset");
    PlayerX = 10'd300;
    dive_go = 1'b1;
    tick(); push_exp("dive_entry", 100, 50, DIVE, 1, 0);
    dive_go = 1'b0;
    tick(10); push_exp("dive_10", 110, 70, DIVE, 1, 0);
    dive_go = 1'b1;
    tick(192); push_exp("dive_bottom", 300, 454, DIVE, 1, 0);
    dive_go = 1'b0;
    tick(); push_exp("dive_wrap", 300, 0, RETURN, 1, 0);
    tick(24); push_exp("return_near", 324, 48, RETURN, 1, 0);
    tick(); push_exp("return_home", 329, 50, FORM, 1, 0);

    // Missile overlapping but inactive
    PlayerMissileX = 10'd110; PlayerMissileY = 10'd60; missile_active = 1'b0;
    reset_to(100, 50, "inactive_reset");
    tick(); push_exp("inactive_no_hit", 101, 50, FORM, 1, 0);

    // Hit, explosion timing, death
    missile_active = 1'b1;
    reset_to(100, 50, "hit_reset");
    tick(); push_exp("hit", 100, 50, EXPLODE, 1, 1);
    missile_active = 1'b0;
    tick(); push_exp("hit_one_frame", 100, 50, EXPLODE, 1, 0);
    tick(6); push_exp("explode_last", 100, 50, EXPLODE, 1, 0);
    tick(); push_exp("dead", 100, 50, DEAD, 0, 0);
    PlayerMissileX = 10'd105; PlayerMissileY = 10'd55; missile_active = 1'b1;
    tick(); push_exp("dead_no_hit", 100, 50, DEAD, 0, 0);

    // Hit beats dive_go, then reset mid-explosion
    PlayerMissileX = 10'd110; PlayerMissileY = 10'd60;
    reset_to(100, 50, "hitdive_reset");
    dive_go = 1'b1;
    tick(); push_exp("hit_beats_dive", 100, 50, EXPLODE, 1, 1);
    dive_go = 1'b0; missile_active = 1'b0;
    tick(2); push_exp("mid_explode", 100, 50, EXPLODE, 1, 0);
    reset_to(200, 80, "reset_mid_explode");
    tick(); push_exp("after_explode_reset", 201, 80, FORM, 1, 0);

    // Touching edges only
    reset_to(100, 50, "touch_reset");
    PlayerMissileX = 10'd125; PlayerMissileY = 10'd60; missile_active = 1'b1;
    tick(); push_exp("touch_right", 101, 50, FORM, 1, 0);
    PlayerMissileX = 10'd98;
    tick(); push_exp("touch_left", 102, 50, FORM, 1, 0);
    PlayerMissileX = 10'd110; PlayerMissileY = 10'd44;
    tick(); push_exp("touch_top", 103, 50, FORM, 1, 0);
    missile_active = 1'b0;

    tick(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
